// File: rtl/seq_loader_ctrl.sv
// -----------------------------------------------------------------------------
// seq_loader_ctrl
//
// Purpose:
//   Loads two nucleotide sequences (A, then B) from a UART byte stream into
//   external sequence buffers, then kicks off the alignment engine and waits
//   for it to finish. Bytes G/C/A/T are encoded to 3-bit symbols. 0x0A ends
//   a sequence. Any other byte is rejected with a one-cycle err pulse.
//
// Optional feature:
//   SEQ_LOWERCASE_EN - when defined, g/c/a/t are accepted as their uppercase
//                      forms. When undefined, lowercase bytes are rejected.
//
// Parameters:
//   N    UART data byte width
//   LEN  maximum symbols per sequence (1 <= LEN <= 2**AW-1)
//   AW   width of the address and length outputs
//
// Ports:
//   clk         system clock; all logic runs on the rising edge
//   rst         synchronous active-high reset
//   rx_done     one-cycle strobe; Rxdata_out is valid in this cycle
//   Rxdata_out  received byte
//   nw_done     one-cycle strobe; the alignment engine has finished
//   wr_en_a     write strobe into the sequence-A buffer
//   wr_en_b     write strobe into the sequence-B buffer
//   wr_addr     write address (0-based)
//   wr_char     encoded nucleotide to write
//   len_a       committed length of sequence A
//   len_b       committed length of sequence B
//   nw_start    one-cycle pulse that starts the alignment engine
//   busy        high while the alignment engine runs
//   err         one-cycle pulse for each rejected byte
//
// All outputs are registered.
//
// state  | meaning
// -------+---------------------------------------------------------------
// LOAD_A | collecting symbols of sequence A
// LOAD_B | collecting symbols of sequence B
// START  | both lengths committed; pulse nw_start
// RUN    | alignment engine running; wait for nw_done
// -----------------------------------------------------------------------------
module seq_loader_ctrl #(
  parameter int N   = 8,
  parameter int LEN = 16,
  parameter int AW  = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_done,
  input  logic [N-1:0]  Rxdata_out,
  input  logic          nw_done,
  output logic          wr_en_a,
  output logic          wr_en_b,
  output logic [AW-1:0] wr_addr,
  output logic [2:0]    wr_char,
  output logic [AW-1:0] len_a,
  output logic [AW-1:0] len_b,
  output logic          nw_start,
  output logic          busy,
  output logic          err
);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    START  = 2'd2,
    RUN    = 2'd3
  } state_t;

  localparam logic [N-1:0]  BYTE_G    = N'(8'h47);
  localparam logic [N-1:0]  BYTE_C    = N'(8'h43);
  localparam logic [N-1:0]  BYTE_A    = N'(8'h41);
  localparam logic [N-1:0]  BYTE_T    = N'(8'h54);
  localparam logic [N-1:0]  BYTE_TERM = N'(8'h0A);
`ifdef SEQ_LOWERCASE_EN
  localparam logic [N-1:0]  BYTE_G_LC = N'(8'h67);
  localparam logic [N-1:0]  BYTE_C_LC = N'(8'h63);
  localparam logic [N-1:0]  BYTE_A_LC = N'(8'h61);
  localparam logic [N-1:0]  BYTE_T_LC = N'(8'h74);
`endif

  localparam logic [2:0]    CODE_G = 3'b001;
  localparam logic [2:0]    CODE_C = 3'b110;
  localparam logic [2:0]    CODE_A = 3'b100;
  localparam logic [2:0]    CODE_T = 3'b011;

  localparam logic [AW-1:0] LEN_C  = AW'(LEN);

  state_t        r_state;
  logic [AW-1:0] r_count;
  logic          r_wr_en_a;
  logic          r_wr_en_b;
  logic [AW-1:0] r_wr_addr;
  logic [2:0]    r_wr_char;
  logic [AW-1:0] r_len_a;
  logic [AW-1:0] r_len_b;
  logic          r_nw_start;
  logic          r_busy;
  logic          r_err;

  logic          w_sym_valid;
  logic [2:0]    w_sym_code;
  logic          w_is_term;
  logic          w_loading;
  logic          w_last;
  logic          w_commit;
  logic [AW-1:0] w_commit_len;
  logic [AW-1:0] w_count_inc;

  // Byte decoder
  always_comb begin
    w_sym_valid = 1'b1;
    w_sym_code  = 3'b000;
    unique case (Rxdata_out)
      BYTE_G:    w_sym_code = CODE_G;
      BYTE_C:    w_sym_code = CODE_C;
      BYTE_A:    w_sym_code = CODE_A;
      BYTE_T:    w_sym_code = CODE_T;
`ifdef SEQ_LOWERCASE_EN
      BYTE_G_LC: w_sym_code = CODE_G;
      BYTE_C_LC: w_sym_code = CODE_C;
      BYTE_A_LC: w_sym_code = CODE_A;
      BYTE_T_LC: w_sym_code = CODE_T;
`endif
      default:   w_sym_valid = 1'b0;
    endcase
  end

  assign w_is_term   = (Rxdata_out == BYTE_TERM);
  assign w_loading   = (r_state == LOAD_A) || (r_state == LOAD_B);
  assign w_count_inc = r_count + 1'b1;
  assign w_last      = (w_count_inc == LEN_C);

  // A sequence is committed either by the write that fills it or by a
  // terminator after at least one symbol. An empty terminator is a no-op.
  assign w_commit     = w_loading && rx_done &&
                        ((w_sym_valid && w_last) ||
                         (!w_sym_valid && w_is_term && (r_count != '0)));
  assign w_commit_len = w_sym_valid ? LEN_C : r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= LOAD_A;
      r_count    <= '0;
      r_wr_en_a  <= 1'b0;
      r_wr_en_b  <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_char  <= 3'b000;
      r_len_a    <= '0;
      r_len_b    <= '0;
      r_nw_start <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_wr_en_a  <= 1'b0;
      r_wr_en_b  <= 1'b0;
      r_nw_start <= 1'b0;
      r_err      <= 1'b0;

      case (r_state)
        LOAD_A, LOAD_B: begin
          if (rx_done) begin
            if (w_sym_valid) begin
              r_wr_en_a <= (r_state == LOAD_A);
              r_wr_en_b <= (r_state == LOAD_B);
              r_wr_addr <= r_count;
              r_wr_char <= w_sym_code;
              r_count   <= w_count_inc;
            end else if (!w_is_term) begin
              r_err <= 1'b1;
            end
          end
          // Overrides the increment above when the sequence is complete.
          if (w_commit) begin
            r_count <= '0;
            if (r_state == LOAD_A) begin
              r_len_a <= w_commit_len;
              r_state <= LOAD_B;
            end else begin
              r_len_b <= w_commit_len;
              r_state <= START;
            end
          end
        end

        START: begin
          r_nw_start <= 1'b1;
          r_busy     <= 1'b1;
          r_state    <= RUN;
          if (rx_done) r_err <= 1'b1;
        end

        RUN: begin
          // A byte arriving while the engine owns the buffers is dropped.
          if (rx_done) r_err <= 1'b1;
          if (nw_done) begin
            r_busy  <= 1'b0;
            r_state <= LOAD_A;
          end
        end

        default: begin
          r_state <= LOAD_A;
          r_count <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign wr_en_a  = r_wr_en_a;
  assign wr_en_b  = r_wr_en_b;
  assign wr_addr  = r_wr_addr;
  assign wr_char  = r_wr_char;
  assign len_a    = r_len_a;
  assign len_b    = r_len_b;
  assign nw_start = r_nw_start;
  assign busy     = r_busy;
  assign err      = r_err;

endmodule
